// File: rtl/spi_flash_master.sv
// spi_flash_master: x1 SPI mode-0 command engine driving the configuration-flash
// pins through the STARTUPE3 wrapper (opcode, address, dummy, write and read phases).
module spi_flash_master #(
    parameter int CLK_DIV     = 2,
    parameter int CS_HIGH_CYC = 8,
    parameter int INIT_PULSES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EOS,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [23:0] cmd_addr,
    input  logic        cmd_addr_en,
    input  logic [3:0]  cmd_dummy,
    input  logic [8:0]  cmd_wr_len,
    input  logic [8:0]  cmd_rd_len,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        USRCCLKO,
    output logic        FCSBO,
    output logic        DO_0,
    output logic        DO_1,
    output logic        DO_2,
    output logic        DO_3,
    output logic        DTS_0,
    output logic        DTS_1,
    output logic        DTS_2,
    output logic        DTS_3,
    input  logic        DI_1
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HIGH_CYC - 1);
    localparam logic [7:0]        INIT_CNT  = 8'(INIT_PULSES);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_CLK,
        S_CS_HOLD,
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_DUMMY,
        S_WRITE,
        S_WR_WAIT,
        S_READ,
        S_CS_END
    } state_t;

    state_t            state;
    state_t            nxt_phase;
    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        bit_cnt;
    logic [8:0]        byte_cnt;
    logic [23:0]       sh;
    logic [6:0]        rx_sh;
    logic [23:0]       addr_q;
    logic              addr_en_q;
    logic [3:0]        dummy_q;
    logic [8:0]        wr_len_q;
    logic [8:0]        rd_len_q;
    logic              from_init;
    logic [3:0]        do_q;
    logic [3:0]        dts_q;
    logic              tick;
    logic              last_bit;

    assign {DO_3, DO_2, DO_1, DO_0}     = do_q;
    assign {DTS_3, DTS_2, DTS_1, DTS_0} = dts_q;
    assign tick     = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == 8'd1);

    // Phase that follows the one currently ending; zero-length phases are skipped.
    always_comb begin
        nxt_phase = S_CS_END;
        if (state == S_OPCODE && addr_en_q)
            nxt_phase = S_ADDR;
        else if ((state == S_OPCODE || state == S_ADDR) && dummy_q != 4'd0)
            nxt_phase = S_DUMMY;
        else if (state != S_WRITE && state != S_READ && wr_len_q != 9'd0)
            nxt_phase = S_WRITE;
        else if (state != S_READ && rd_len_q != 9'd0)
            nxt_phase = S_READ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT_WAIT;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            sh        <= '0;
            rx_sh     <= '0;
            addr_q    <= '0;
            addr_en_q <= 1'b0;
            dummy_q   <= '0;
            wr_len_q  <= '0;
            rd_len_q  <= '0;
            from_init <= 1'b1;
            do_q      <= 4'h0;
            dts_q     <= 4'hF;
            FCSBO     <= 1'b1;
            USRCCLKO  <= 1'b0;
            cmd_ready <= 1'b0;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_INIT_WAIT: begin
                    if (EOS) begin
                        // DTS_1 stays an input for MISO; HOLD#/WP# driven high.
                        dts_q    <= 4'b0010;
                        do_q     <= 4'b1100;
                        div_cnt  <= '0;
                        hold_cnt <= '0;
                        bit_cnt  <= INIT_CNT;
                        state    <= (INIT_CNT == 8'd0) ? S_CS_HOLD : S_INIT_CLK;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        addr_en_q <= cmd_addr_en;
                        dummy_q   <= cmd_dummy;
                        wr_len_q  <= (cmd_wr_len > 9'd256) ? 9'd256 : cmd_wr_len;
                        rd_len_q  <= (cmd_rd_len > 9'd256) ? 9'd256 : cmd_rd_len;
                        sh        <= {cmd_opcode[6:0], 17'h0};
                        do_q[0]   <= cmd_opcode[7];
                        FCSBO     <= 1'b0;
                        bit_cnt   <= 8'd8;
                        div_cnt   <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_OPCODE;
                    end
                end
                S_WR_WAIT: begin
                    if (tx_valid) begin
                        sh       <= {tx_data[6:0], 17'h0};
                        do_q[0]  <= tx_data[7];
                        tx_ready <= 1'b1;
                        bit_cnt  <= 8'd8;
                        div_cnt  <= '0;
                        state    <= S_WRITE;
                    end
                end
                S_CS_END: begin
                    if (tick) begin
                        FCSBO    <= 1'b1;
                        div_cnt  <= '0;
                        hold_cnt <= '0;
                        state    <= S_CS_HOLD;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_CS_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= ~from_init;
                        from_init <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    // Bit engine: rise samples MISO, fall presents the next bit.
                    if (!tick) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else if (!USRCCLKO) begin
                        div_cnt  <= '0;
                        USRCCLKO <= 1'b1;
                        if (state == S_READ) begin
                            rx_sh <= {rx_sh[5:0], DI_1};
                            if (last_bit) begin
                                rx_data  <= {rx_sh, DI_1};
                                rx_valid <= 1'b1;
                            end
                        end
                    end else begin
                        div_cnt  <= '0;
                        USRCCLKO <= 1'b0;
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt - 8'd1;
                            sh      <= {sh[22:0], 1'b0};
                            if (state inside {S_OPCODE, S_ADDR, S_WRITE})
                                do_q[0] <= sh[23];
                        end else if (state == S_INIT_CLK) begin
                            hold_cnt <= '0;
                            state    <= S_CS_HOLD;
                        end else if (state == S_READ && byte_cnt != 9'd1) begin
                            byte_cnt <= byte_cnt - 9'd1;
                            bit_cnt  <= 8'd8;
                        end else if ((state == S_WRITE && byte_cnt != 9'd1) ||
                                     (state != S_WRITE && nxt_phase == S_WRITE)) begin
                            // Next write byte only starts once a whole byte is available.
                            byte_cnt <= (state == S_WRITE) ? byte_cnt - 9'd1 : wr_len_q;
                            bit_cnt  <= 8'd8;
                            if (tx_valid) begin
                                sh       <= {tx_data[6:0], 17'h0};
                                do_q[0]  <= tx_data[7];
                                tx_ready <= 1'b1;
                                state    <= S_WRITE;
                            end else begin
                                state <= S_WR_WAIT;
                            end
                        end else begin
                            case (nxt_phase)
                                S_ADDR: begin
                                    sh      <= {addr_q[22:0], 1'b0};
                                    do_q[0] <= addr_q[23];
                                    bit_cnt <= 8'd24;
                                    state   <= S_ADDR;
                                end
                                S_DUMMY: begin
                                    do_q[0] <= 1'b0;
                                    bit_cnt <= {4'h0, dummy_q};
                                    state   <= S_DUMMY;
                                end
                                S_READ: begin
                                    do_q[0]  <= 1'b0;
                                    bit_cnt  <= 8'd8;
                                    byte_cnt <= rd_len_q;
                                    state    <= S_READ;
                                end
                                default: begin
                                    do_q[0] <= 1'b0;
                                    state   <= S_CS_END;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_master.sv
// tb_spi_flash_master: directed bench around spi_flash_master with a small
// behavioural flash that captures MOSI on SCK rise and shifts MISO on SCK fall.
`timescale 1ns/1ps
module tb_spi_flash_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        EOS = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [23:0] cmd_addr = 24'h0;
    logic        cmd_addr_en = 1'b0;
    logic [3:0]  cmd_dummy = 4'h0;
    logic [8:0]  cmd_wr_len = 9'd0;
    logic [8:0]  cmd_rd_len = 9'd0;
    logic [7:0]  tx_data;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        USRCCLKO;
    logic        FCSBO;
    logic        DO_0, DO_1, DO_2, DO_3;
    logic        DTS_0, DTS_1, DTS_2, DTS_3;
    logic        di_1;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int tx_cnt = 0;
    int rx_cnt = 0;
    int init_sck = 0;
    int sck_total = 0;
    int fall_total = 0;
    int fall_base = 0;
    int sck_base = 0;
    int done_base = 0;
    int rx_base = 0;
    int n_pre = 0;
    int rel;
    logic [127:0] mosi_log = '0;
    logic [31:0]  resp_bits = '0;
    logic [7:0]   rx_log [64];
    logic [7:0]   wr_bytes [4];

    spi_flash_master #(.CLK_DIV(2), .CS_HIGH_CYC(8), .INIT_PULSES(3)) dut (
        .clk(clk), .reset(reset), .EOS(EOS),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_addr(cmd_addr), .cmd_addr_en(cmd_addr_en), .cmd_dummy(cmd_dummy),
        .cmd_wr_len(cmd_wr_len), .cmd_rd_len(cmd_rd_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .USRCCLKO(USRCCLKO), .FCSBO(FCSBO),
        .DO_0(DO_0), .DO_1(DO_1), .DO_2(DO_2), .DO_3(DO_3),
        .DTS_0(DTS_0), .DTS_1(DTS_1), .DTS_2(DTS_2), .DTS_3(DTS_3),
        .DI_1(di_1)
    );

    always #5 clk = ~clk;

    assign tx_data = wr_bytes[tx_cnt[1:0]];

    // Flash MISO: read bit k is driven after the (n_pre + k)-th SCK fall of the transaction.
    always_comb begin
        rel  = fall_total - fall_base - n_pre;
        di_1 = 1'b0;
        if (!FCSBO && rel >= 0 && rel < 32) di_1 = resp_bits[5'(31 - rel)];
    end

    always @(posedge USRCCLKO) begin
        if (FCSBO) init_sck++;
        else begin
            sck_total++;
            mosi_log = {mosi_log[126:0], DO_0};
        end
    end

    always @(negedge USRCCLKO) if (!FCSBO) fall_total++;
    always @(negedge FCSBO) fall_base = fall_total;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (tx_ready) tx_cnt++;
        if (rx_valid) begin
            rx_log[rx_cnt[5:0]] = rx_data;
            rx_cnt++;
        end
    end

    function automatic logic [7:0] get_rx(input int i);
        return rx_log[i[5:0]];
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic timeout_fail(input string tag);
        tests++;
        fails++;
        $error("[TB] FAIL %s: observed timeout, expected event within bound", tag);
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [23:0] addr,
                                 input logic addr_en, input logic [3:0] dummy,
                                 input logic [8:0] wr_len, input logic [8:0] rd_len);
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout_fail("cmd_ready_wait");
        sck_base    = sck_total;
        done_base   = done_cnt;
        rx_base     = rx_cnt;
        cmd_opcode  = op;
        cmd_addr    = addr;
        cmd_addr_en = addr_en;
        cmd_dummy   = dummy;
        cmd_wr_len  = wr_len;
        cmd_rd_len  = rd_len;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == done_base) timeout_fail({tag, "_done"});
        repeat (2) @(negedge clk);
        checkOutput({tag, "_done_pulses"}, 128'(done_cnt - done_base), 128'd1);
    endtask

    initial begin
        int n;
        int init_base;
        int hi_cnt;
        logic stall_bad;

        wr_bytes = '{8'hA5, 8'h3C, 8'h7E, 8'h81};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_pins", {FCSBO, USRCCLKO, DO_3, DO_2, DO_1, DO_0, DTS_3, DTS_2, DTS_1, DTS_0},
                    {1'b1, 1'b0, 4'h0, 4'hF});
        checkOutput("reset_ctrl", {cmd_ready, tx_ready, rx_valid, done, busy}, 5'b00001);
        checkOutput("reset_rx_data", rx_data, 8'h00);

        // Bring-up: EOS low keeps the engine waiting
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("eos_wait_sck", 128'(init_sck), 128'd0);
        checkOutput("eos_wait_dts", {DTS_3, DTS_2, DTS_1, DTS_0}, 4'hF);
        EOS = 1'b1;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout_fail("init_ready");
        checkOutput("init_pulses", 128'(init_sck), 128'd3);
        checkOutput("init_no_done", 128'(done_cnt), 128'd0);
        checkOutput("init_dts", {DTS_3, DTS_2, DTS_1, DTS_0}, 4'b0010);
        checkOutput("init_do", {DO_3, DO_2, DO_1, DO_0}, 4'b1100);
        checkOutput("init_idle", {FCSBO, busy}, 2'b10);

        // Read ID
        resp_bits = 32'hEF401800;
        n_pre = 8;
        applyStimulus(8'h9F, 24'h0, 1'b0, 4'd0, 9'd0, 9'd3);
        wait_done("read_id");
        checkOutput("read_id_sck", 128'(sck_total - sck_base), 128'd32);
        checkOutput("read_id_mosi", mosi_log[31:0], 32'h9F000000);
        checkOutput("read_id_rx_cnt", 128'(rx_cnt - rx_base), 128'd3);
        checkOutput("read_id_rx", {get_rx(rx_base), get_rx(rx_base + 1), get_rx(rx_base + 2)},
                    24'hEF4018);

        // Fast read with address and dummy cycles
        resp_bits = 32'hC35A01FE;
        n_pre = 40;
        applyStimulus(8'h0B, 24'h123456, 1'b1, 4'd8, 9'd0, 9'd4);
        wait_done("fast_read");
        checkOutput("fast_read_sck", 128'(sck_total - sck_base), 128'd72);
        checkOutput("fast_read_mosi", mosi_log[71:0], {8'h0B, 24'h123456, 40'h0});
        checkOutput("fast_read_rx_cnt", 128'(rx_cnt - rx_base), 128'd4);
        checkOutput("fast_read_rx", {get_rx(rx_base), get_rx(rx_base + 1), get_rx(rx_base + 2),
                    get_rx(rx_base + 3)}, 32'hC35A01FE);

        // Page program with tx_valid dropped before byte 3
        n_pre = 1000;
        tx_valid = 1'b1;
        applyStimulus(8'h02, 24'h000100, 1'b1, 4'd0, 9'd4, 9'd0);
        n = 0;
        while (tx_cnt < 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx_cnt < 2) timeout_fail("pp_two_bytes");
        tx_valid = 1'b0;
        stall_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i >= 40 && (USRCCLKO || FCSBO)) stall_bad = 1'b1;
        end
        checkOutput("pp_stall_pins", stall_bad, 1'b0);
        checkOutput("pp_stall_sck", 128'(sck_total - sck_base), 128'd48);
        checkOutput("pp_stall_tx_ready", 128'(tx_cnt), 128'd2);
        tx_valid = 1'b1;
        wait_done("page_program");
        checkOutput("pp_sck", 128'(sck_total - sck_base), 128'd64);
        checkOutput("pp_mosi", mosi_log[63:0], 64'h02000100A53C7E81);
        checkOutput("pp_tx_ready", 128'(tx_cnt), 128'd4);
        tx_valid = 1'b0;

        // Write enable; a cmd_valid while busy must be ignored
        applyStimulus(8'h06, 24'h0, 1'b0, 4'd0, 9'd0, 9'd0);
        @(negedge clk);
        cmd_opcode = 8'hFF;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!FCSBO && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!FCSBO) timeout_fail("wren_cs_rise");
        hi_cnt = 0;
        while (FCSBO && !cmd_ready && hi_cnt < 100) begin
            @(negedge clk);
            hi_cnt++;
        end
        checkOutput("wren_cs_high_min", (hi_cnt >= 8 && FCSBO && cmd_ready), 1'b1);
        wait_done("wren");
        checkOutput("wren_sck", 128'(sck_total - sck_base), 128'd8);
        checkOutput("wren_mosi", mosi_log[7:0], 8'h06);

        // Reset during READ
        resp_bits = 32'hEF401800;
        n_pre = 8;
        applyStimulus(8'h9F, 24'h0, 1'b0, 4'd0, 9'd0, 9'd3);
        n = 0;
        while (rx_cnt == rx_base && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rx_cnt == rx_base) timeout_fail("abort_first_byte");
        init_base = init_sck;
        reset = 1'b1;
        #1;
        checkOutput("abort_pins", {FCSBO, USRCCLKO}, 2'b10);
        checkOutput("abort_ctrl", {cmd_ready, busy, rx_data}, {1'b0, 1'b1, 8'h00});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout_fail("reinit_ready");
        repeat (2) @(negedge clk);
        checkOutput("reinit_pulses", 128'(init_sck - init_base), 128'd3);
        checkOutput("reinit_no_done", 128'(done_cnt - done_base), 128'd0);

        // Command after re-init
        resp_bits = 32'h5AA5C300;
        n_pre = 8;
        applyStimulus(8'h9F, 24'h0, 1'b0, 4'd0, 9'd0, 9'd3);
        wait_done("post_reset");
        checkOutput("post_reset_sck", 128'(sck_total - sck_base), 128'd32);
        checkOutput("post_reset_mosi", mosi_log[31:0], 32'h9F000000);
        checkOutput("post_reset_rx", {get_rx(rx_base), get_rx(rx_base + 1), get_rx(rx_base + 2)},
                    24'h5AA5C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
